// File: rtl/idelay_cal_pkg.sv
// Shared definitions for the IDELAY tap calibration block: state encoding,
// tap/window widths and small window arithmetic helpers.
package idelay_cal_pkg;

  localparam int TAP_W = 9;
  localparam int WIN_W = 10;

  // Longest window that can be reported; the window length saturates here.
  localparam logic [WIN_W-1:0] WIN_SAT = 10'd512;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WAIT_RDY = 4'd1,
    ST_LOAD0    = 4'd2,
    ST_SETTLE   = 4'd3,
    ST_SAMPLE   = 4'd4,
    ST_STEP     = 4'd5,
    ST_CENTER   = 4'd6,
    ST_DONE     = 4'd7,
    ST_FAIL     = 4'd8
  } cal_state_e;

  // Window length increment with saturation.
  function automatic logic [WIN_W-1:0] win_inc(input logic [WIN_W-1:0] len);
    return (len >= WIN_SAT) ? WIN_SAT : len + WIN_W'(1);
  endfunction

  // Middle tap of a window, truncated to the tap width.
  function automatic logic [TAP_W-1:0] win_center(input logic [TAP_W-1:0] start,
                                                  input logic [WIN_W-1:0] len);
    logic [WIN_W-1:0] sum;
    sum = {1'b0, start} + (len >> 1);
    return sum[TAP_W-1:0];
  endfunction

endpackage

// File: rtl/idelay_cal_checker.sv
// Training-pattern checker: compares every lane's {q2,q1} pair against the
// expected pattern and counts consecutive matching cycles while enabled.
// pass_o fires on the SAMPLE_CYCLES-th consecutive match, fail_o on the first
// mismatch. Both are combinational strobes consumed by the calibration FSM.
module idelay_cal_checker #(
  parameter int         WIDTH         = 1,
  parameter logic [1:0] TRAIN_PATTERN = 2'b10,
  parameter int         SAMPLE_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] q1_i,
  input  logic [WIDTH-1:0] q2_i,
  output logic             pass_o,
  output logic             fail_o
);

  localparam int CNT_W = $clog2(SAMPLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             match;

  // All lanes must show the training pattern in the same cycle.
  always_comb begin
    match = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if ({q2_i[i], q1_i[i]} != TRAIN_PATTERN) begin
        match = 1'b0;
      end
    end
  end

  // Consecutive-match counting; the count restarts whenever sampling stops.
  always_comb begin
    cnt_d  = '0;
    pass_o = 1'b0;
    fail_o = 1'b0;
    if (en_i) begin
      if (!match) begin
        fail_o = 1'b1;
      end else if (cnt_q == CNT_LAST) begin
        pass_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Match counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/idelay_tap_cal.sv
// IDELAY tap calibration: sweeps the delay line from tap 0 to TAP_MAX,
// qualifies each tap against a training pattern, tracks the longest passing
// window and finally loads the centre of that window. All outputs are
// registered copies of next-state decodes, so nothing reaches an output
// combinationally from q1/q2.
module idelay_tap_cal
  import idelay_cal_pkg::*;
#(
  parameter int         WIDTH         = 1,
  parameter logic [1:0] TRAIN_PATTERN = 2'b10,
  parameter int         SETTLE_CYCLES = 16,
  parameter int         SAMPLE_CYCLES = 64,
  parameter int         MIN_WINDOW    = 8,
  parameter int         TAP_MAX       = 511
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             idelay_rdy,
  input  logic [WIDTH-1:0] q1,
  input  logic [WIDTH-1:0] q2,
  output logic             dly_en,
  output logic             dly_inc,
  output logic             dly_load,
  output logic [8:0]       dly_cnt_value,
  output logic             dly_en_vtc,
  output logic             cal_done,
  output logic             cal_fail,
  output logic [8:0]       cal_tap,
  output logic [9:0]       win_len
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SET_W-1:0] CENTER_LAST = SET_W'(SETTLE_CYCLES);
  localparam logic [TAP_W-1:0] TAP_LAST    = TAP_W'(TAP_MAX);
  localparam logic [WIN_W-1:0] MIN_LEN     = WIN_W'(MIN_WINDOW);

  cal_state_e       state_q, state_d;
  logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [TAP_W-1:0] cur_start_q, cur_start_d;
  logic [WIN_W-1:0] cur_len_q, cur_len_d;
  logic [TAP_W-1:0] best_start_q, best_start_d;
  logic [WIN_W-1:0] best_len_q, best_len_d;

  logic             dly_en_q, dly_en_d;
  logic             dly_inc_q, dly_inc_d;
  logic             dly_load_q, dly_load_d;
  logic [TAP_W-1:0] dly_cnt_value_q, dly_cnt_value_d;
  logic             dly_en_vtc_q, dly_en_vtc_d;
  logic             cal_done_q, cal_done_d;
  logic             cal_fail_q, cal_fail_d;
  logic [TAP_W-1:0] cal_tap_q, cal_tap_d;
  logic [WIN_W-1:0] win_len_q, win_len_d;

  logic             chk_pass;
  logic             chk_fail;
  logic             at_max;
  logic             scanning;
  logic [TAP_W-1:0] cls_start;
  logic [WIN_W-1:0] cls_len;

  assign at_max   = (tap_q == TAP_LAST);
  assign scanning = (state_q == ST_LOAD0) || (state_q == ST_SETTLE) ||
                    (state_q == ST_SAMPLE) || (state_q == ST_STEP) ||
                    (state_q == ST_CENTER);

  idelay_cal_checker #(
    .WIDTH        (WIDTH),
    .TRAIN_PATTERN(TRAIN_PATTERN),
    .SAMPLE_CYCLES(SAMPLE_CYCLES)
  ) u_checker (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (state_q == ST_SAMPLE),
    .q1_i  (q1),
    .q2_i  (q2),
    .pass_o(chk_pass),
    .fail_o(chk_fail)
  );

  // Next state, scan counters and window bookkeeping.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    tap_d        = tap_q;
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    cls_start    = cur_start_q;
    cls_len      = cur_len_q;

    case (state_q)
      ST_IDLE: ;
      ST_WAIT_RDY: begin
        if (idelay_rdy) begin
          state_d = ST_LOAD0;
        end
      end
      ST_LOAD0: begin
        tap_d        = '0;
        cur_start_d  = '0;
        cur_len_d    = '0;
        best_start_d = '0;
        best_len_d   = '0;
        settle_cnt_d = '0;
        state_d      = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
      end
      ST_SAMPLE: begin
        if (chk_pass || chk_fail) begin
          // A passing tap opens or extends the current window.
          if (chk_pass) begin
            if (cur_len_q == '0) begin
              cls_start = tap_q;
            end
            cls_len = win_inc(cur_len_q);
          end
          cur_start_d = cls_start;
          cur_len_d   = cls_len;
          // The window closes on a failing tap or at the end of the sweep;
          // strict compare keeps the earlier window on a tie.
          if (chk_fail || at_max) begin
            if (cls_len > best_len_q) begin
              best_start_d = cls_start;
              best_len_d   = cls_len;
            end
            cur_len_d = '0;
          end
          settle_cnt_d = '0;
          if (!at_max) begin
            state_d = ST_STEP;
          end else if (best_len_d >= MIN_LEN) begin
            state_d = ST_CENTER;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_STEP: begin
        tap_d        = tap_q + TAP_W'(1);
        settle_cnt_d = '0;
        state_d      = ST_SETTLE;
      end
      ST_CENTER: begin
        // First CENTER cycle carries the load strobe, then the line settles.
        if (settle_cnt_q == CENTER_LAST) begin
          state_d = ST_DONE;
        end else begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
      end
      ST_DONE: ;
      ST_FAIL: ;
      default: state_d = ST_IDLE;
    endcase

    // Losing the delay controller abandons the sweep; it restarts from tap 0.
    if (scanning && !idelay_rdy) begin
      state_d = ST_WAIT_RDY;
    end
    if (start) begin
      state_d = ST_WAIT_RDY;
    end
  end

  // Output decode from the next state so every output is a plain register.
  always_comb begin
    dly_en_d        = (state_d == ST_STEP);
    dly_inc_d       = (state_d == ST_STEP);
    dly_load_d      = (state_d == ST_LOAD0) ||
                      ((state_d == ST_CENTER) && (state_q != ST_CENTER));
    dly_cnt_value_d = dly_cnt_value_q;
    dly_en_vtc_d    = !((state_d == ST_LOAD0) || (state_d == ST_SETTLE) ||
                        (state_d == ST_SAMPLE) || (state_d == ST_STEP) ||
                        (state_d == ST_CENTER));
    cal_done_d      = (state_d == ST_DONE);
    cal_fail_d      = (state_d == ST_FAIL);
    cal_tap_d       = cal_tap_q;
    win_len_d       = win_len_q;

    if (state_d == ST_LOAD0) begin
      dly_cnt_value_d = '0;
    end else if ((state_d == ST_CENTER) && (state_q != ST_CENTER)) begin
      dly_cnt_value_d = win_center(best_start_d, best_len_d);
    end

    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      cal_tap_d = win_center(best_start_q, best_len_q);
      win_len_d = best_len_q;
    end else if ((state_d == ST_FAIL) && (state_q != ST_FAIL)) begin
      cal_tap_d = '0;
      win_len_d = best_len_d;
    end
  end

  // State, scan and window registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      tap_q        <= '0;
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      tap_q        <= tap_d;
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_en_q        <= 1'b0;
      dly_inc_q       <= 1'b0;
      dly_load_q      <= 1'b0;
      dly_cnt_value_q <= '0;
      dly_en_vtc_q    <= 1'b1;
      cal_done_q      <= 1'b0;
      cal_fail_q      <= 1'b0;
      cal_tap_q       <= '0;
      win_len_q       <= '0;
    end else begin
      dly_en_q        <= dly_en_d;
      dly_inc_q       <= dly_inc_d;
      dly_load_q      <= dly_load_d;
      dly_cnt_value_q <= dly_cnt_value_d;
      dly_en_vtc_q    <= dly_en_vtc_d;
      cal_done_q      <= cal_done_d;
      cal_fail_q      <= cal_fail_d;
      cal_tap_q       <= cal_tap_d;
      win_len_q       <= win_len_d;
    end
  end

  assign dly_en        = dly_en_q;
  assign dly_inc       = dly_inc_q;
  assign dly_load      = dly_load_q;
  assign dly_cnt_value = dly_cnt_value_q;
  assign dly_en_vtc    = dly_en_vtc_q;
  assign cal_done      = cal_done_q;
  assign cal_fail      = cal_fail_q;
  assign cal_tap       = cal_tap_q;
  assign win_len       = win_len_q;

endmodule
